// File: rtl/alu_exec.sv
// Multi-cycle EX-stage execution unit: single-cycle logic/arithmetic ops and
// bit-serial shifts behind a start/busy/done handshake.
module alu_exec #(
  parameter int WIDTH = 32,
  parameter int SHW   = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       ctrl,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [SHW-1:0]   shamt,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             overflow,
  output logic             illegal
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t state, state_nxt;

  logic [WIDTH-1:0]        acc, acc_nxt;
  logic [SHW-1:0]          cnt;
  logic                    shl;
  logic                    accept;
  logic                    is_shift;
  logic                    shift_multi;
  logic [WIDTH-1:0]        op_res;
  logic                    op_ovf;
  logic                    op_ill;
  logic signed [WIDTH-1:0] sa, sb, sum, diff;

  function automatic logic add_ovf(input logic signed [WIDTH-1:0] x, y, s);
    return (x[WIDTH-1] == y[WIDTH-1]) && (s[WIDTH-1] != x[WIDTH-1]);
  endfunction

  function automatic logic sub_ovf(input logic signed [WIDTH-1:0] x, y, d);
    return (x[WIDTH-1] != y[WIDTH-1]) && (d[WIDTH-1] != x[WIDTH-1]);
  endfunction

  assign sa   = a;
  assign sb   = b;
  assign sum  = sa + sb;
  assign diff = sa - sb;

  always_comb begin
    op_res   = '0;
    op_ovf   = 1'b0;
    op_ill   = 1'b0;
    is_shift = 1'b0;
    case (ctrl)
      4'b0000: op_res = a & b;
      4'b0001: op_res = a | b;
      4'b0010: begin
        op_res = sum;
        op_ovf = add_ovf(sa, sb, sum);
      end
      4'b0100: begin
        op_res = diff;
        op_ovf = sub_ovf(sa, sb, diff);
      end
      4'b1000, 4'b1001: begin
        op_res   = b;
        is_shift = 1'b1;
      end
      default: op_ill = 1'b1;
    endcase
  end

  // A zero-amount shift completes like a single-cycle op with result = b.
  assign shift_multi = is_shift && (shamt != '0);
  assign accept      = start && (state != SHIFT);
  assign acc_nxt     = shl ? {acc[WIDTH-2:0], 1'b0} : {1'b0, acc[WIDTH-1:1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = (state == SHIFT);
    done      = (state == DONE);
    case (state)
      IDLE, DONE: begin
        if (start) state_nxt = shift_multi ? SHIFT : DONE;
        else       state_nxt = IDLE;
      end
      SHIFT:   if (cnt == SHW'(1)) state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc      <= '0;
      cnt      <= '0;
      shl      <= 1'b0;
      result   <= '0;
      zero     <= 1'b0;
      overflow <= 1'b0;
      illegal  <= 1'b0;
    end else if (accept) begin
      if (shift_multi) begin
        acc <= b;
        cnt <= shamt;
        shl <= ~ctrl[0];
      end else begin
        result   <= op_res;
        zero     <= (op_res == '0);
        overflow <= op_ovf;
        illegal  <= op_ill;
      end
    end else if (state == SHIFT) begin
      acc <= acc_nxt;
      cnt <= cnt - SHW'(1);
      // Final shift step publishes the result; shifts never overflow.
      if (cnt == SHW'(1)) begin
        result   <= acc_nxt;
        zero     <= (acc_nxt == '0);
        overflow <= 1'b0;
        illegal  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_exec.sv
// Self-checking bench for alu_exec: directed scenarios plus randomized ops
// compared against an arithmetic reference model.
module tb_alu_exec;

  localparam int WIDTH = 32;
  localparam int SHW   = 5;
  localparam longint MAXP = 2147483647;
  localparam longint MINN = -MAXP - 1;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic [3:0]       ctrl;
  logic [WIDTH-1:0] a, b;
  logic [SHW-1:0]   shamt;
  logic             busy, done, zero, overflow, illegal;
  logic [WIDTH-1:0] result;

  int checks = 0;
  int errors = 0;

  alu_exec #(.WIDTH(WIDTH), .SHW(SHW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .ctrl(ctrl), .a(a), .b(b),
    .shamt(shamt), .busy(busy), .done(done), .result(result), .zero(zero),
    .overflow(overflow), .illegal(illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference model: what the op means, not how the unit computes it.
  task automatic model(input logic [3:0] c, input logic [31:0] av, input logic [31:0] bv,
                       input logic [4:0] sh, output logic [31:0] r, output logic ov,
                       output logic il, output int lat, output int bcyc);
    longint s;
    r = 32'h0; ov = 1'b0; il = 1'b0; lat = 1; bcyc = 0;
    case (c)
      4'b0000: r = av & bv;
      4'b0001: r = av | bv;
      4'b0010: begin
        s  = longint'($signed(av)) + longint'($signed(bv));
        r  = av + bv;
        ov = (s > MAXP) || (s < MINN);
      end
      4'b0100: begin
        s  = longint'($signed(av)) - longint'($signed(bv));
        r  = av - bv;
        ov = (s > MAXP) || (s < MINN);
      end
      4'b1000, 4'b1001: begin
        r    = (c == 4'b1000) ? (bv << sh) : (bv >> sh);
        lat  = int'(sh) + 1;
        bcyc = int'(sh);
      end
      default: il = 1'b1;
    endcase
  endtask

  task automatic do_op(input string tag, input logic [3:0] c, input logic [31:0] av,
                       input logic [31:0] bv, input logic [4:0] sh, input bit poke);
    logic [31:0] er;
    logic        eo, ei;
    int          elat, ebusy, lat, bcnt;
    model(c, av, bv, sh, er, eo, ei, elat, ebusy);
    @(negedge clk);
    start = 1'b1; ctrl = c; a = av; b = bv; shamt = sh;
    @(negedge clk);
    start = 1'b0; a = $urandom; b = $urandom; shamt = 5'($urandom);
    lat = 1; bcnt = 0;
    while (!done && lat < 40) begin
      if (busy) bcnt++;
      @(negedge clk);
      start = (poke && lat == 3);
      lat++;
    end
    start = 1'b0;
    check({tag, ".latency"}, lat, elat);
    check({tag, ".busy_cycles"}, bcnt, ebusy);
    check({tag, ".busy_at_done"}, busy, 1'b0);
    check({tag, ".result"}, result, er);
    check({tag, ".zero"}, zero, (er == 32'h0));
    check({tag, ".overflow"}, overflow, eo);
    check({tag, ".illegal"}, illegal, ei);
    @(negedge clk);
    check({tag, ".done_pulse"}, done, 1'b0);
    check({tag, ".hold"}, result, er);
  endtask

  initial begin
    logic [31:0] er;
    logic        eo, ei;
    int          elat, ebusy, seen;
    logic [3:0]  rc;
    logic [4:0]  rs;

    rst_n = 1'b0; start = 1'b0; ctrl = 4'h0; a = '0; b = '0; shamt = '0;
    #12;
    check("reset.busy", busy, 1'b0);
    check("reset.done", done, 1'b0);
    check("reset.result", result, 32'h0);
    check("reset.flags", {zero, overflow, illegal}, 3'b000);
    @(negedge clk);
    rst_n = 1'b1;

    do_op("add_ovf", 4'b0010, 32'h7FFFFFFF, 32'h1, 5'd0, 1'b0);
    do_op("sub_zero", 4'b0100, 32'h5, 32'h5, 5'd0, 1'b0);
    do_op("add_pos", 4'b0010, 32'h12345678, 32'h1, 5'd0, 1'b0);

    // Reset in the middle of a long shift
    @(negedge clk);
    start = 1'b1; ctrl = 4'b1000; b = 32'h1; shamt = 5'd20;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    check("rst_mid.busy_before", busy, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid.busy", busy, 1'b0);
    check("rst_mid.done", done, 1'b0);
    check("rst_mid.result", result, 32'h0);
    check("rst_mid.flags", {zero, overflow, illegal}, 3'b000);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (25) begin
      @(negedge clk);
      if (done || busy) seen++;
    end
    check("rst_mid.no_done_after", seen, 0);

    // Back-to-back single-cycle ops with start held high
    @(negedge clk);
    start = 1'b1; ctrl = 4'b0000; a = 32'hF0F0F0F0; b = 32'hFF00FF00; shamt = '0;
    @(negedge clk);
    check("b2b.done1", done, 1'b1);
    check("b2b.result1", result, 32'hF000F000);
    ctrl = 4'b0001; a = 32'h0F; b = 32'hF0;
    @(negedge clk);
    start = 1'b0;
    check("b2b.done2", done, 1'b1);
    check("b2b.result2", result, 32'h000000FF);
    @(negedge clk);
    check("b2b.done3", done, 1'b0);

    do_op("sll31", 4'b1000, 32'h1, 32'h1, 5'd31, 1'b1);
    do_op("srl4", 4'b1001, 32'h0, 32'h80000000, 5'd4, 1'b0);
    do_op("srl0", 4'b1001, 32'h0, 32'h1234, 5'd0, 1'b0);
    do_op("illegal", 4'b0111, 32'hDEAD, 32'hBEEF, 5'd3, 1'b0);
    do_op("after_ill", 4'b0001, 32'h1, 32'h2, 5'd0, 1'b0);
    do_op("sub_ovf", 4'b0100, 32'h80000000, 32'h1, 5'd0, 1'b0);
    do_op("sll_clear_ovf", 4'b1000, 32'h0, 32'hFFFFFFFF, 5'd2, 1'b0);

    // Randomized ops, including illegal codes
    for (int i = 0; i < 40; i++) begin
      rc = 4'($urandom);
      if (i % 3 != 0) begin
        case ($urandom_range(0, 5))
          0: rc = 4'b0000;
          1: rc = 4'b0001;
          2: rc = 4'b0010;
          3: rc = 4'b0100;
          4: rc = 4'b1000;
          default: rc = 4'b1001;
        endcase
      end
      rs = 5'($urandom);
      do_op("rand", rc, $urandom, $urandom, rs, ($urandom_range(0, 3) == 0));
    end

    // Model cross-check on an idle hold: outputs stay put with no start
    model(4'b0010, 32'h1, 32'h2, 5'd0, er, eo, ei, elat, ebusy);
    do_op("add_small", 4'b0010, 32'h1, 32'h2, 5'd0, 1'b0);
    repeat (5) @(negedge clk);
    check("idle.hold", result, er);
    check("idle.done", done, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_exec.md
# alu_exec

Multi-cycle execution unit that consumes the 4-bit ALU control code produced by the ALU control decoder and performs the selected operation on two 32-bit operands. Logic and arithmetic ops complete in one cycle. Shifts run iteratively, one bit per cycle, to keep the datapath small. It sits in the EX stage between the register-file read ports and the write-back mux, and uses a start/busy/done handshake toward the stage controller.

## Interface
Parameters:
- WIDTH, 32, operand/result width
- SHW, 5, shift-amount width (log2 WIDTH)

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  request; sampled only when the unit is idle
- ctrl  in  4  op code: 0000 AND, 0001 OR, 0010 ADD, 0100 SUB, 1000 SLL, 1001 SRL; anything else is illegal
- a  in  WIDTH  operand A (AND/OR/ADD/SUB)
- b  in  WIDTH  operand B; the shifted operand for SLL/SRL
- shamt  in  SHW  shift amount
- busy  out  1  high while a shift is in progress
- done  out  1  one-cycle pulse; result and flags valid
- result  out  WIDTH  registered result, held until the next accepted start
- zero  out  1  result == 0, registered with result
- overflow  out  1  signed overflow of ADD/SUB; 0 for other ops
- illegal  out  1  ctrl was not a listed code

## Operation
- States: IDLE, SHIFT, DONE.
- Accept: a clock edge with start=1 while the state is IDLE or DONE. Operands, ctrl and shamt are captured at that edge; later input changes are ignored.
- start while in SHIFT is ignored. No queueing is performed.
- AND/OR/ADD/SUB/illegal:
  - result, zero, overflow and illegal are computed and registered at the accept edge.
  - Next state is DONE.
- Arithmetic:
  - ADD/SUB wrap modulo 2^WIDTH.
  - ADD overflow = (a[msb]==b[msb]) && (sum[msb]!=a[msb]).
  - SUB overflow = (a[msb]!=b[msb]) && (diff[msb]!=a[msb]).
- Illegal ctrl: result=0, zero=1, overflow=0, illegal=1.
- SLL/SRL, shamt=0: result=b is registered at the accept edge; next state is DONE.
- SLL/SRL, shamt=N>0:
  - At the accept edge, acc=b and cnt=N; next state is SHIFT.
  - Each edge in SHIFT shifts acc by one bit (SLL: left, zero-fill LSB; SRL: logical right, zero-fill MSB) and decrements cnt.
  - The edge where cnt goes 1→0 writes result/zero and moves to DONE.
- DONE:
  - done=1 for exactly one cycle.
  - Next state is IDLE, or back into the op path if start is accepted in that cycle (back-to-back).
- No accept in IDLE: stay in IDLE; outputs hold.
- result, zero, overflow and illegal change only at completion edges and hold otherwise.

## Timing
- Reset (async, immediate): state=IDLE, busy=0, done=0, result=0, zero=0, overflow=0, illegal=0, acc=0, cnt=0.
- Reset asserted mid-shift aborts the operation; no done is produced.
- Latency, measured from the cycle start is high to the cycle done is high:
  - 1 cycle for AND/OR/ADD/SUB/illegal and for shifts with shamt=0.
  - N+1 cycles for a shift with shamt=N>0. The maximum is 32 (N=31).
- busy = (state==SHIFT). It rises in the cycle after accept and falls in the done cycle.
- Throughput: one single-cycle op per clock when start is held high (done high every cycle). A shift blocks new starts for N cycles.
- done and busy are never high together.
- overflow is cleared by shift completions.

## Test plan
- Reset mid-shift: SLL b=1, shamt=20; assert rst_n=0 at cycle 5 → all outputs 0 immediately. After release, no done until the next start.
- ADD a=0x7FFFFFFF, b=1 → next cycle done=1, result=0x80000000, overflow=1, zero=0. Then SUB a=5, b=5 → result=0, zero=1, overflow=0.
- Back-to-back: start held high over AND (0xF0F0F0F0 & 0xFF00FF00) then OR (0x0F & 0xF0) → done on two consecutive cycles, results 0xF000F000 then 0x000000FF.
- SLL b=0x00000001, shamt=31 → busy high for 31 cycles, done 32 cycles after start, result=0x80000000. start pulsed mid-shift is ignored (result unchanged, no extra done).
- SRL b=0x80000000, shamt=4 → done after 5 cycles, result=0x08000000. Then SRL with shamt=0, b=0x1234 → done after 1 cycle, result=0x1234, busy never high.
- Illegal ctrl=4'b0111 → done after 1 cycle, illegal=1, result=0, zero=1. The next legal op clears illegal.
